range_scan_fsmd: RTL
====================

// Module: range_scan_fsmd
// PURPOSE
// - Parametrised scanner: reads memory words start_addr..end_addr (inclusive); returns min, max, max_diff = max - min.
// - Generalises the 8-bit max-diff FSMD with these parameters:
//   - data width, address width and signedness are parameters;
//   - streams one read per cycle;
//   - supports abort;
//   - flags a bad range on err.
// - Sits between the top-level control (start/busy/done) and a synchronous-read RAM port.
// PARAMETERS
// - DW      8  data word width
// - AW      8  address width
// - SIGNED  0  0 = unsigned compare; 1 = two's-complement compare
// PORTS
// - clk         in   1     single clock, rising edge
// - rst         in   1     asynchronous, active-high reset
// - start       in   1     request scan; sampled only in IDLE
// - abort       in   1     cancel scan in progress
// - start_addr  in   AW    first address, inclusive
// - end_addr    in   AW    last address, inclusive
// - mem_rd      out  1     read strobe
// - mem_addr    out  AW    read address
// - mem_rdata   in   DW    read data, valid exactly 1 cycle after mem_rd
// - busy        out  1     scan in progress
// - done        out  1     1-cycle pulse: results updated
// - err         out  1     range error on last start; held until next accepted start
// - min_val     out  DW    minimum of last completed scan
// - max_val     out  DW    maximum of last completed scan
// - max_diff    out  DW+1  max_val - min_val, always non-negative
// BEHAVIOUR
// - Reset: every output = 0; FSM = IDLE. Reset mid-scan discards all progress.
// - FSM states:
//   - IDLE:  start=1 latches start_addr/end_addr and clears err.
//            - start_addr > end_addr -> ERR.
//            - otherwise -> SCAN.
//            - start=0 -> stay IDLE.
//   - SCAN:  mem_rd=1; mem_addr=i; i starts at start_addr.
//            - i == end_addr -> DRAIN.
//            - otherwise i <= i+1.
//            - Equality compare only; end_addr = 2^AW-1 terminates with no wrap.
//   - DRAIN: capture the last returned word -> DIFF.
//   - DIFF:  register min_val, max_val, max_diff; done=1 -> IDLE.
//   - ERR:   err=1, done=1 for 1 cycle; min/max/max_diff unchanged -> IDLE.
// - Data capture: the word returned for start_addr initialises run_min and run_max. Each later word:
//   - updates run_min if data < run_min (strict);
//   - updates run_max if data > run_max (strict).
// - Arithmetic:
//   - Compare signed when SIGNED=1.
//   - max_diff = sign/zero-extend max to DW+1, minus min extended the same way.
//   - No overflow is possible.
// - Timing: N = end_addr - start_addr + 1. start accepted at edge T:
//   - mem_rd high for cycles T+1..T+N;
//   - data returns T+2..T+N+1;
//   - done high in cycle T+N+2;
//   - busy high for cycles T+1..T+N+1 and low in the done cycle.
// - ERR path: busy stays 0; err and done go high in cycle T+1.
// - start while busy: ignored. start in the same cycle done is high: ignored (FSM not yet IDLE).
// - abort=1 in SCAN or DRAIN:
//   - next state IDLE; mem_rd drops the next cycle;
//   - no done; outputs keep the previous results.
//   - abort is ignored in IDLE, DIFF and ERR.
// - Results hold until the next done. Internal run_min/run_max never appear on the outputs mid-scan.
// CONFIGURATION
// - RANGE_SCAN_ARGIDX_EN defined:
//   - adds outputs min_idx and max_idx (AW bits each; reset 0);
//   - each holds the address of the first occurrence of min/max;
//   - both update with done.
// - Not defined: these ports and their registers do not exist; all other behaviour is identical.
// TESTING
// - Unsigned, DW=8, RAM[0..3]={0x10,0x80,0x05,0x40}, start_addr=0, end_addr=3:
//   min=0x05, max=0x80, max_diff=0x07B; done 6 cycles after the start edge.
// - SIGNED=1, RAM[0..2]={0x7F,0x80,0x00}:
//   min=0x80, max=0x7F, max_diff=0x0FF; with ARGIDX, min_idx=1, max_idx=0.
// - start_addr=end_addr=0xFF, RAM[0xFF]=0x33:
//   exactly 1 mem_rd; max_diff=0; mem_addr never wraps to 0x00.
// - start_addr=5, end_addr=2:
//   err=1 and done=1 one cycle later; no mem_rd; previous results held.
// - abort 2 cycles into an 8-word scan:
//   no done; mem_rd low one cycle later; results unchanged; the next start completes normally.
// - rst pulsed mid-scan:
//   all outputs 0 immediately (async); FSM IDLE; start is accepted after release.

Source files
------------

// File: rtl/range_scan_fsmd.sv
// range_scan_fsmd
// Scans a synchronous-read RAM from start_addr to end_addr (inclusive), one
// read per cycle, and reports min, max and max_diff = max - min.
// DW/AW set data/address width; SIGNED selects two's-complement compares.
// Optional feature macro: RANGE_SCAN_ARGIDX_EN adds o_min_idx/o_max_idx,
// the address of the first occurrence of the minimum/maximum.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; range check on the accepting edge
// S_SCAN  | one read per cycle from start_addr up to end_addr
// S_DRAIN | last word returns; final results are registered
// S_DIFF  | results visible, done pulse
// S_ERR   | start_addr > end_addr: err held, done pulse, results untouched

module range_scan_fsmd #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int SIGNED = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [AW-1:0] i_start_addr,
    input  logic [AW-1:0] i_end_addr,
    output logic          o_mem_rd,
    output logic [AW-1:0] o_mem_addr,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [DW-1:0] o_min_val,
    output logic [DW-1:0] o_max_val,
`ifdef RANGE_SCAN_ARGIDX_EN
    output logic [AW-1:0] o_min_idx,
    output logic [AW-1:0] o_max_idx,
`endif
    output logic [DW:0]   o_max_diff
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_DRAIN = 3'd2,
        S_DIFF  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_range_bad;

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_end;
    logic          r_vld;
    logic          r_first;
    logic          r_err;
    logic [DW-1:0] r_run_min;
    logic [DW-1:0] r_run_max;

    logic          w_take_min;
    logic          w_take_max;
    logic [DW-1:0] w_min_next;
    logic [DW-1:0] w_max_next;
    logic [DW:0]   w_ext_min;
    logic [DW:0]   w_ext_max;

`ifdef RANGE_SCAN_ARGIDX_EN
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_run_min_idx;
    logic [AW-1:0] r_run_max_idx;
    logic [AW-1:0] w_min_idx_next;
    logic [AW-1:0] w_max_idx_next;
`endif

    // a < b under the configured signedness
    function automatic logic f_lt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0) return ($signed(a) < $signed(b));
        else             return (a < b);
    endfunction

    assign w_range_bad = (i_start_addr > i_end_addr);
    assign o_mem_addr  = r_addr;
    assign o_err       = r_err;

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state and control outputs
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        o_mem_rd = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = w_range_bad ? S_ERR : S_SCAN;
                end
            end
            S_SCAN: begin
                o_mem_rd = 1'b1;
                o_busy   = 1'b1;
                if (i_abort)              w_next = S_IDLE;
                else if (r_addr == r_end) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                w_next = i_abort ? S_IDLE : S_DIFF;
            end
            S_DIFF: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // address counter; stops on equality so end_addr = all-ones never wraps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
            r_end  <= '0;
        end else if (w_accept) begin
            r_addr <= i_start_addr;
            r_end  <= i_end_addr;
        end else if (r_state == S_SCAN && !i_abort && r_addr != r_end) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // read-data valid one cycle behind the strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_vld <= 1'b0;
        else       r_vld <= o_mem_rd;
    end

`ifdef RANGE_SCAN_ARGIDX_EN
    // address of the word currently on i_mem_rdata
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rd_addr <= '0;
        else       r_rd_addr <= o_mem_addr;
    end
`endif

    // fold the returning word into the running min/max (strict compares keep first occurrence)
    always_comb begin
        w_take_min = r_first || f_lt(i_mem_rdata, r_run_min);
        w_take_max = r_first || f_lt(r_run_max, i_mem_rdata);
        w_min_next = w_take_min ? i_mem_rdata : r_run_min;
        w_max_next = w_take_max ? i_mem_rdata : r_run_max;
        w_ext_min  = {(SIGNED != 0) & w_min_next[DW-1], w_min_next};
        w_ext_max  = {(SIGNED != 0) & w_max_next[DW-1], w_max_next};
`ifdef RANGE_SCAN_ARGIDX_EN
        w_min_idx_next = w_take_min ? r_rd_addr : r_run_min_idx;
        w_max_idx_next = w_take_max ? r_rd_addr : r_run_max_idx;
`endif
    end

    // running accumulators; a new start re-arms the first-word load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_first   <= 1'b1;
            r_run_min <= '0;
            r_run_max <= '0;
`ifdef RANGE_SCAN_ARGIDX_EN
            r_run_min_idx <= '0;
            r_run_max_idx <= '0;
`endif
        end else if (w_accept) begin
            r_first <= 1'b1;
        end else if (r_vld) begin
            r_first   <= 1'b0;
            r_run_min <= w_min_next;
            r_run_max <= w_max_next;
`ifdef RANGE_SCAN_ARGIDX_EN
            r_run_min_idx <= w_min_idx_next;
            r_run_max_idx <= w_max_idx_next;
`endif
        end
    end

    // result registers: loaded as DRAIN completes so they are valid during done
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_min_val  <= '0;
            o_max_val  <= '0;
            o_max_diff <= '0;
`ifdef RANGE_SCAN_ARGIDX_EN
            o_min_idx  <= '0;
            o_max_idx  <= '0;
`endif
        end else if (r_state == S_DRAIN && !i_abort) begin
            o_min_val  <= w_min_next;
            o_max_val  <= w_max_next;
            o_max_diff <= w_ext_max - w_ext_min;
`ifdef RANGE_SCAN_ARGIDX_EN
            o_min_idx  <= w_min_idx_next;
            o_max_idx  <= w_max_idx_next;
`endif
        end
    end

    // range error flag: set or cleared on every accepted start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_err <= 1'b0;
        else if (w_accept) r_err <= w_range_bad;
    end

endmodule
